// File: rtl/issue_buffer_pkg.sv
// Shared decode/issue types: instruction class codes, branch codes and the
// PC_set record that flows from decode through the issue buffer.
package issue_buffer_pkg;

  localparam logic [9:0] INST_ALU   = 10'h001;
  localparam logic [9:0] INST_MUL   = 10'h004;
  localparam logic [9:0] INST_DIV   = 10'h008;
  localparam logic [9:0] INST_ERTN  = 10'h020;
  localparam logic [9:0] INST_CACOP = 10'h080;
  localparam logic [9:0] BR_NONE    = 10'h001;

  typedef struct packed {
    logic        o_valid;
    logic [31:0] pc;
    logic [9:0]  inst_type;
    logic [9:0]  br_type;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic        ecode_we;
  } PC_set;

  // Instructions that change privileged state or raise exceptions go alone.
  function automatic logic issues_alone(PC_set s);
    return (s.inst_type == INST_ERTN) || (s.inst_type == INST_CACOP) || s.ecode_we;
  endfunction

endpackage

// File: rtl/issue_buffer_if.sv
// Decode-side push pair, back-end control and issue-side pair of the buffer.
interface issue_buffer_if
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  PC_set            d_set1;
  PC_set            d_set2;
  logic             d_ready;
  logic             flush_BR;
  logic             stall_DCache;
  logic             stall_div;
  PC_set            i_set1;
  PC_set            i_set2;
  logic [CNT_W-1:0] buf_count;

  modport master (
    output d_set1, d_set2, flush_BR, stall_DCache, stall_div,
    input  d_ready, i_set1, i_set2, buf_count
  );

  modport slave (
    input  d_set1, d_set2, flush_BR, stall_DCache, stall_div,
    output d_ready, i_set1, i_set2, buf_count
  );
endinterface

// File: rtl/issue_buffer_pair_check.sv
// Decides whether the second-oldest entry may issue alongside the oldest.
// Purely combinational so the perf counters can reuse it.
module issue_pair_check
  import issue_buffer_pkg::*;
(
  input  PC_set entry0,
  input  PC_set entry1,
  output logic  pair_ok
);
  logic non_alu_ok;
  logic raw_ok;
  logic br_ok;
  logic solo_ok;

  // Only one non-ALU op per pair; it is steered to pipe B.
  assign non_alu_ok = !((entry0.inst_type != INST_ALU) && (entry1.inst_type != INST_ALU));
  // No forwarding inside a pair, so a younger reader of the older result waits.
  assign raw_ok     = !(entry0.rf_we && (entry0.rf_rd != 5'd0) &&
                        ((entry1.rf_raddr1 == entry0.rf_rd) ||
                         (entry1.rf_raddr2 == entry0.rf_rd)));
  assign br_ok      = (entry0.br_type == BR_NONE);
  assign solo_ok    = !(issues_alone(entry0) || issues_alone(entry1));
  assign pair_ok    = non_alu_ok && raw_ok && br_ok && solo_ok;

endmodule

// File: rtl/issue_buffer.sv
// Decoupling queue between decode and Issue_EXE: circular PC_set storage,
// dual push, dual issue. Issue outputs are read straight from the head slots.
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  issue_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  PC_set            mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head_nxt, tail_nxt;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       push_n, pop_n;
  logic             d_ready, push_en, wr1, wr2, stall, pair_ok;
  PC_set            ent0, ent1, i1, i2;

  assign head_nxt = head_q + PTR_W'(1);
  assign ent0     = mem_q[head_q];
  assign ent1     = mem_q[head_nxt];

  issue_pair_check u_pair_check (
    .entry0  (ent0),
    .entry1  (ent1),
    .pair_ok (pair_ok)
  );

  // Issue slots: payload from the head slots, valids from occupancy and pairing.
  always_comb begin
    i1         = ent0;
    i2         = ent1;
    i1.o_valid = (count_q != '0);
    i2.o_valid = (count_q >= CNT_W'(2)) && pair_ok;
  end

  // Credit is judged on registered occupancy only; same-cycle pops are ignored.
  assign d_ready  = (count_q <= CNT_W'(DEPTH - 2));
  assign push_en  = d_ready && !bus.flush_BR;
  assign wr1      = push_en && bus.d_set1.o_valid;
  assign wr2      = push_en && bus.d_set2.o_valid;
  assign tail_nxt = tail_q + PTR_W'(wr1);
  assign push_n   = {1'b0, wr1} + {1'b0, wr2};

  assign stall    = bus.stall_DCache || bus.stall_div;
  assign pop_n    = stall ? 2'd0 : ({1'b0, i1.o_valid} + {1'b0, i2.o_valid});

  assign head_d   = head_q + PTR_W'(pop_n);
  assign tail_d   = tail_q + PTR_W'(push_n);
  assign count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);

  // Pointer/occupancy state; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.flush_BR) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; compacted writes so a lone d_set2 lands at tail.
  always_ff @(posedge clk) begin
    if (wr1) mem_q[tail_q]   <= bus.d_set1;
    if (wr2) mem_q[tail_nxt] <= bus.d_set2;
  end

  assign bus.i_set1    = i1;
  assign bus.i_set2    = i2;
  assign bus.d_ready   = d_ready;
  assign bus.buf_count = count_q;

endmodule
